decode_stage_sb: RTL

//  Registered instruction decode stage with valid/ready handshake and a register scoreboard.

---
 rtl/decode_stage_sb.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/decode_stage_sb.sv
// Registered decode stage: field split, immediate extension, control flags,
// and a per-register pending-write scoreboard that stalls fetch on RAW/WAW hazards.
module decode_stage_sb #(
  parameter int INSTRUCTION_WIDTH = 33,
  parameter int WIDTH_OPCODE      = 5,
  parameter int REGFILE_ADDR_BITS = 4,
  parameter int IMMEDIATE_WIDTH   = 16,
  parameter int DATA_WIDTH        = 32,
  parameter bit IMM_SIGNED        = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH_OPCODE-1:0]      out_opcode,
  output logic [REGFILE_ADDR_BITS-1:0] out_rd,
  output logic [REGFILE_ADDR_BITS-1:0] out_rs1,
  output logic [REGFILE_ADDR_BITS-1:0] out_rs2,
  output logic [DATA_WIDTH-1:0]        out_imm,
  output logic                         out_reg_write,
  output logic                         out_mem_read,
  output logic                         out_mem_write,
  output logic                         out_branch,
  output logic                         out_illegal,
  input  logic                         wb_valid,
  input  logic [REGFILE_ADDR_BITS-1:0] wb_addr,
  input  logic                         flush
);

  localparam int IW   = INSTRUCTION_WIDTH;
  localparam int OW   = WIDTH_OPCODE;
  localparam int RA   = REGFILE_ADDR_BITS;
  localparam int IMW  = IMMEDIATE_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int NREG = 2 ** RA;

  localparam logic [OW-1:0] OP_NOP  = OW'(0);
  localparam logic [OW-1:0] OP_LR   = OW'(1);
  localparam logic [OW-1:0] OP_LI   = OW'(2);
  localparam logic [OW-1:0] OP_SR   = OW'(3);
  localparam logic [OW-1:0] OP_MOVE = OW'(4);
  localparam logic [OW-1:0] OP_ADD  = OW'(5);
  localparam logic [OW-1:0] OP_ADDI = OW'(6);
  localparam logic [OW-1:0] OP_SUB  = OW'(7);
  localparam logic [OW-1:0] OP_CMP  = OW'(8);
  localparam logic [OW-1:0] OP_AND  = OW'(9);
  localparam logic [OW-1:0] OP_OR   = OW'(10);
  localparam logic [OW-1:0] OP_NOT  = OW'(11);
  localparam logic [OW-1:0] OP_SHL  = OW'(12);
  localparam logic [OW-1:0] OP_SHR  = OW'(13);
  localparam logic [OW-1:0] OP_BNE  = OW'(14);
  localparam logic [OW-1:0] OP_BE   = OW'(15);

  logic [OW-1:0]   w_op;
  logic [RA-1:0]   w_rd;
  logic [RA-1:0]   w_rs1;
  logic [RA-1:0]   w_rs2;
  logic [IMW-1:0]  w_imm;
  logic [DW-1:0]   w_imm_ext;
  logic            w_legal;
  logic            w_rd_rd;
  logic            w_rd_rs1;
  logic            w_rd_rs2;
  logic            w_wr;
  logic            w_mr;
  logic            w_mw;
  logic            w_br;
  logic            w_sext;
  logic            w_hazard;
  logic            w_accept;
  logic [NREG-1:0] w_pending_nxt;

  logic            r_out_valid;
  logic [NREG-1:0] r_pending;
  logic [OW-1:0]   r_opcode;
  logic [RA-1:0]   r_rd;
  logic [RA-1:0]   r_rs1;
  logic [RA-1:0]   r_rs2;
  logic [DW-1:0]   r_imm;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_branch;
  logic            r_illegal;

  assign w_op    = in_instr[IW-1 -: OW];
  assign w_rd    = in_instr[IW-OW-1 -: RA];
  assign w_rs1   = in_instr[IW-OW-RA-1 -: RA];
  assign w_rs2   = in_instr[IW-OW-2*RA-1 -: RA];
  assign w_imm   = in_instr[IMW-1:0];
  assign w_legal = (int'(w_op) < 16);

  always_comb begin
    w_rd_rd  = 1'b0;
    w_rd_rs1 = 1'b0;
    w_rd_rs2 = 1'b0;
    w_wr     = 1'b0;
    w_mr     = 1'b0;
    w_mw     = 1'b0;
    w_br     = 1'b0;
    if (w_legal) begin
      case (w_op)
        OP_NOP: ;
        OP_LR:   begin w_rd_rs1 = 1'b1; w_wr = 1'b1; w_mr = 1'b1; end
        OP_LI:   w_wr = 1'b1;
        OP_SR:   begin w_rd_rd = 1'b1; w_rd_rs1 = 1'b1; w_mw = 1'b1; end
        OP_MOVE: begin w_rd_rs1 = 1'b1; w_wr = 1'b1; end
        OP_ADD, OP_SUB, OP_AND, OP_OR:
                 begin w_rd_rs1 = 1'b1; w_rd_rs2 = 1'b1; w_wr = 1'b1; end
        OP_ADDI: begin w_rd_rd = 1'b1; w_wr = 1'b1; end
        OP_CMP:  begin w_rd_rd = 1'b1; w_rd_rs1 = 1'b1; end
        OP_NOT, OP_SHL, OP_SHR:
                 begin w_rd_rs1 = 1'b1; w_wr = 1'b1; end
        OP_BNE, OP_BE:
                 begin w_rd_rd = 1'b1; w_rd_rs1 = 1'b1; w_br = 1'b1; end
        default: ;
      endcase
    end
  end

  // Branch offsets are always signed, whatever the global immediate mode.
  assign w_sext    = IMM_SIGNED | w_br;
  assign w_imm_ext = {{(DW-IMW){w_sext & w_imm[IMW-1]}}, w_imm};

  assign w_hazard = in_valid & ((w_rd_rd  & r_pending[w_rd])  |
                                (w_rd_rs1 & r_pending[w_rs1]) |
                                (w_rd_rs2 & r_pending[w_rs2]) |
                                (w_wr     & r_pending[w_rd]));

  assign in_ready = ~reset & ~flush & ~w_hazard & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  // Clears first so that a same-edge set of the same register wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (flush && r_out_valid && r_reg_write) w_pending_nxt[r_rd] = 1'b0;
    if (wb_valid) w_pending_nxt[wb_addr] = 1'b0;
    if (w_accept && w_wr && (w_rd != '0)) w_pending_nxt[w_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_pending   <= '0;
      r_opcode    <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_imm       <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_opcode    <= w_op;
        r_rd        <= w_rd;
        r_rs1       <= w_rs1;
        r_rs2       <= w_rs2;
        r_imm       <= w_imm_ext;
        r_reg_write <= w_wr;
        r_mem_read  <= w_mr;
        r_mem_write <= w_mw;
        r_branch    <= w_br;
        r_illegal   <= ~w_legal;
      end else if (flush || out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_opcode    = r_opcode;
  assign out_rd        = r_rd;
  assign out_rs1       = r_rs1;
  assign out_rs2       = r_rs2;
  assign out_imm       = r_imm;
  assign out_reg_write = r_reg_write;
  assign out_mem_read  = r_mem_read;
  assign out_mem_write = r_mem_write;
  assign out_branch    = r_branch;
  assign out_illegal   = r_illegal;

endmodule
